// File: rtl/velocidade_pkg.sv
// velocidade_pkg: speed codes and FSM state type shared by the speed selector, action mux and display decode
package velocidade_pkg;
   localparam logic [1:0] VEL_PARADO = 2'b00;
   localparam logic [1:0] VEL_LENTO  = 2'b01;
   localparam logic [1:0] VEL_RAPIDO = 2'b10;
   typedef enum logic [1:0] {PARADO = VEL_PARADO, LENTO = VEL_LENTO, RAPIDO = VEL_RAPIDO} vel_e;
   function automatic vel_e proxima_vel(input vel_e v);
      return (v == PARADO) ? LENTO : (v == LENTO) ? RAPIDO : PARADO;
   endfunction
endpackage

// File: rtl/filtro_botao.sv
// filtro_botao: two-flop synchroniser plus debounce filter for a single push-button level
module filtro_botao #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic entrada,
   output logic saida
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ULTIMO = CW'(DEBOUNCE_CYCLES - 1);
   logic s1_q, s2_q, deb_q, deb_d;
   logic [CW-1:0] cnt_q, cnt_d;
   // accept the synced level once it has differed for DEBOUNCE_CYCLES edges in a row
   always_comb begin
      deb_d = (s2_q != deb_q && cnt_q == CNT_ULTIMO) ? s2_q : deb_q;
      cnt_d = (s2_q == deb_q || deb_d != deb_q) ? '0 : cnt_q + 1'b1;
   end
   // synchroniser, debounce counter and accepted level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         deb_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= entrada;
         s2_q  <= s1_q;
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end
   assign saida = deb_q;
endmodule

// File: rtl/seletor_velocidade.sv
// seletor_velocidade: turns the speed push-button into the speed code and a count-reset pulse
module seletor_velocidade
   import velocidade_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 4,
   parameter int LONG_PRESS_CYCLES = 16,
   parameter bit BOTAO_ATIVO_BAIXO = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic power,
   input  logic botao,
   output logic chave_0,
   output logic chave_1,
   output logic reset_contagem_botao
);
   localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
   logic deb, deb_prev_q, rise, fall, long_hit;
   logic [HW-1:0] hold_q, hold_d;
   logic long_q, long_d, armed_q, armed_d, pulse_q, pulse_d;
   vel_e state_q, state_d;

   filtro_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro (
      .clk     (clk),
      .reset   (reset),
      .entrada (BOTAO_ATIVO_BAIXO ? ~botao : botao),
      .saida   (deb)
   );

   assign rise     = deb & ~deb_prev_q;
   assign fall     = ~deb & deb_prev_q;
   assign long_hit = power & deb & (hold_q == HOLD_MAX - 1'b1);

   // armed marks a press that began with power on, so a button held across power-up is not an event
   always_comb begin
      hold_d  = (!power || !deb) ? '0 : (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
      long_d  = !power ? 1'b0 : long_hit ? 1'b1 : fall ? 1'b0 : long_q;
      armed_d = !power ? 1'b0 : rise ? 1'b1 : fall ? 1'b0 : armed_q;
      state_d = (!power || 2'(state_q) == 2'b11 || long_hit) ? PARADO :
                (fall && armed_q && !long_q) ? proxima_vel(state_q) : state_q;
      pulse_d = power && (state_d != state_q);
   end

   // edge-detect history, hold counter, flags, speed state and pulse register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb_prev_q <= 1'b0;
         hold_q     <= '0;
         long_q     <= 1'b0;
         armed_q    <= 1'b0;
         state_q    <= PARADO;
         pulse_q    <= 1'b0;
      end else begin
         deb_prev_q <= deb;
         hold_q     <= hold_d;
         long_q     <= long_d;
         armed_q    <= armed_d;
         state_q    <= state_d;
         pulse_q    <= pulse_d;
      end
   end

   assign {chave_1, chave_0} = state_q;
   assign reset_contagem_botao = pulse_q;
endmodule

// File: tb/tb_seletor_velocidade.sv
// tb_seletor_velocidade: directed stimulus with an edge-history reference model checked every cycle
module tb_seletor_velocidade;
   localparam int D = 4;
   localparam int L = 16;
   logic clk, reset, power, botao;
   logic chave_0, chave_1, pulse;
   int total, passed, pulses, p0;
   int n, last_flip, hold_break, spd, old_spd, exp_pulse;
   bit raw_h [0:4095];
   bit deb_h [0:4095];
   bit deb_m, valid, was_long, flip, rise, fall, long_hit, s2k;

   seletor_velocidade #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .BOTAO_ATIVO_BAIXO(1'b1)) dut (
      .clk                  (clk),
      .reset                (reset),
      .power                (power),
      .botao                (botao),
      .chave_0              (chave_0),
      .chave_1              (chave_1),
      .reset_contagem_botao (pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic press(input int h);
      botao = 1'b0;
      tick(h);
      botao = 1'b1;
      tick(10);
   endtask

   function automatic int code();
      return int'({chave_1, chave_0});
   endfunction

   // reference model: edge-indexed history of the button; deb flips when the last D synced samples
   // since the previous flip all disagree with it; speed advances on valid short releases
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            n = 0; last_flip = 0; hold_break = 0; deb_m = 0; deb_h[0] = 0;
            spd = 0; valid = 0; was_long = 0; exp_pulse = 0;
         end else begin
            old_spd = spd;
            n++;
            raw_h[n] = ~botao;
            deb_h[n] = deb_m;
            flip = (n - D >= last_flip);
            if (flip)
               for (int k = n - D + 1; k <= n; k++) begin
                  s2k = (k >= 3) ? raw_h[k-2] : 1'b0;
                  if (s2k == deb_m) flip = 0;
               end
            rise = deb_h[n] && !deb_h[n-1];
            fall = !deb_h[n] && deb_h[n-1];
            if (!(deb_h[n] && power)) hold_break = n;
            long_hit = power && (n - hold_break == L);
            if (!power) begin
               spd = 0; valid = 0; was_long = 0;
            end else begin
               if (long_hit) begin
                  spd = 0; was_long = 1;
               end else if (fall) begin
                  if (valid && !was_long) spd = (spd + 1) % 3;
                  was_long = 0; valid = 0;
               end
               if (rise) valid = 1;
            end
            exp_pulse = (power && spd != old_spd) ? 1 : 0;
            if (flip) begin
               deb_m = ~deb_m; last_flip = n;
            end
         end
      end
   end

   // per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         chk("model_chave", code(), spd);
         chk("model_pulse", int'(pulse), exp_pulse);
         if (pulse) pulses++;
      end
   end

   initial begin
      total = 0; passed = 0; pulses = 0;
      reset = 1'b1; power = 1'b1; botao = 1'b1;
      tick(2);
      chk("reset_chave", code(), 0);
      chk("reset_pulse", int'(pulse), 0);
      reset = 1'b0;
      tick(3);
      // first press: exact release latency and single-cycle pulse
      botao = 1'b0;
      tick(8);
      botao = 1'b1;
      tick(6);
      chk("lat_before", code(), 0);
      tick(1);
      chk("lat_chave", code(), 1);
      chk("lat_pulse", int'(pulse), 1);
      tick(1);
      chk("pulse_one_cycle", int'(pulse), 0);
      tick(5);
      p0 = pulses;
      press(8);
      chk("cycle_rapido", code(), 2);
      press(8);
      chk("cycle_wrap", code(), 0);
      chk("cycle_pulses", pulses - p0, 2);
      // short glitch never reaches the debounced level
      p0 = pulses;
      botao = 1'b0;
      tick(3);
      botao = 1'b1;
      tick(10);
      chk("glitch_chave", code(), 0);
      chk("glitch_pulses", pulses - p0, 0);
      // long press from RAPIDO
      press(8);
      press(8);
      chk("pre_long", code(), 2);
      p0 = pulses;
      botao = 1'b0;
      tick(21);
      chk("long_edge21", code(), 2);
      tick(1);
      chk("long_edge22", code(), 0);
      chk("long_pulse", int'(pulse), 1);
      tick(8);
      botao = 1'b1;
      tick(12);
      chk("long_release", code(), 0);
      chk("long_pulses", pulses - p0, 1);
      // power drop from LENTO, presses ignored, held button across power-up
      press(8);
      chk("pre_power", code(), 1);
      p0 = pulses;
      power = 1'b0;
      tick(1);
      chk("power_off_chave", code(), 0);
      chk("power_off_pulse", int'(pulse), 0);
      press(8);
      chk("power_off_press", code(), 0);
      botao = 1'b0;
      tick(10);
      power = 1'b1;
      tick(3);
      botao = 1'b1;
      tick(12);
      chk("power_held_release", code(), 0);
      chk("power_pulses", pulses - p0, 0);
      // asynchronous reset during a press debounce
      press(8);
      chk("pre_reset", code(), 1);
      botao = 1'b0;
      tick(3);
      #2 reset = 1'b1;
      #1 chk("async_reset_chave", code(), 0);
      chk("async_reset_pulse", int'(pulse), 0);
      @(negedge clk);
      reset = 1'b0;
      tick(12);
      botao = 1'b1;
      tick(6);
      chk("post_reset_before", code(), 0);
      tick(1);
      chk("post_reset_chave", code(), 1);
      chk("post_reset_pulse", int'(pulse), 1);
      tick(3);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
